// File: rtl/voxel_gpu.sv
// Voxel rasteriser: Avalon-MM register slave plus a byte-wide master that clears
// the frame buffer and plots a voxel list with an orthographic camera offset.
//
// state  | meaning
// IDLE   | waiting for a start command
// PAL0   | fetch palette entry 0 as the clear colour
// CLEAR  | fill the frame buffer with the clear colour
// VFETCH | read x, y, z, c of the current voxel
// PROJ   | project and clip the voxel
// PFETCH | read the voxel colour from the palette
// PLOT   | write the colour to the frame buffer
// DONE   | flag completion and return to IDLE
module voxel_gpu #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s1_address,
  input  logic        s1_read,
  output logic [31:0] s1_readdata,
  input  logic [31:0] s1_writedata,
  input  logic        s1_write,
  output logic        s1_waitrequest,
  output logic        irq,
  output logic [31:0] m1_address,
  output logic [7:0]  m1_writedata,
  output logic        m1_write,
  input  logic        m1_waitrequest,
  input  logic [7:0]  m1_readdata,
  output logic        m1_read,
  input  logic        m1_readdatavalid
);
  localparam logic [31:0] NPIX = 32'(WIDTH * HEIGHT);
  localparam logic [31:0] W32  = 32'(WIDTH);
  localparam logic [9:0]  W10  = 10'(WIDTH);
  localparam logic [9:0]  H10  = 10'(HEIGHT);

  typedef enum logic [2:0] {IDLE, PAL0, CLEAR, VFETCH, PROJ, PFETCH, PLOT, DONE} state_t;
  state_t state;

  logic [31:0] pix_base, vox_base, vox_count, pal_base, pal_len;
  logic [15:0] cam [15];
  logic        busy, done, irq_en;

  logic [31:0] ptr, pix_left, vox_ptr, vox_left, pal_l, pal_len_l, pix_l;
  logic [7:0]  cx, cy, cz, vx, vy, vz, vc, clear_color, pcol;
  logic [1:0]  byte_idx;
  logic        rd_pend;

  logic        rd_done, wr_done, bus_idle, skip, next_vox;
  logic [9:0]  sx, sy;
  logic [31:0] plot_off;
  logic        unused_sig;

  assign unused_sig     = s1_read;
  assign s1_waitrequest = 1'b0;
  assign irq            = done & irq_en;

  assign rd_done  = (m1_read & ~m1_waitrequest & m1_readdatavalid) | (rd_pend & m1_readdatavalid);
  assign wr_done  = m1_write & ~m1_waitrequest;
  assign bus_idle = ~m1_read & ~m1_write & ~rd_pend;

  // Camera integer part is signed, voxel coordinates unsigned.
  assign sx       = {2'b00, vx} - {{2{cx[7]}}, cx};
  assign sy       = {2'b00, vy} - {{2{cy[7]}}, cy};
  assign plot_off = {22'd0, sy} * W32 + {22'd0, sx};
  assign skip     = sx[9] | (sx >= W10) | sy[9] | (sy >= H10)
                  | ($signed({1'b0, vz}) < $signed({cz[7], cz}))
                  | ({24'd0, vc} >= pal_len_l);
  assign next_vox = ((state == PROJ) & skip) | ((state == PLOT) & wr_done);

  always_comb begin
    s1_readdata = 32'd0;
    case (s1_address)
      8'd0: s1_readdata = pix_base;
      8'd1: s1_readdata = vox_base;
      8'd2: s1_readdata = vox_count;
      8'd3: s1_readdata = pal_base;
      8'd4: s1_readdata = pal_len;
      8'd5: s1_readdata = {30'd0, done, busy};
      8'd6: s1_readdata = {31'd0, irq_en};
      default:
        if (s1_address[7:4] == 4'h1 && s1_address[3:0] != 4'hF)
          s1_readdata = {{16{cam[s1_address[3:0]][15]}}, cam[s1_address[3:0]]};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pix_base <= '0; vox_base <= '0; vox_count <= '0; pal_base <= '0; pal_len <= '0;
      for (int i = 0; i < 15; i++) cam[i] <= '0;
      busy <= 1'b0; done <= 1'b0; irq_en <= 1'b0;
      ptr <= '0; pix_left <= '0; vox_ptr <= '0; vox_left <= '0;
      pal_l <= '0; pal_len_l <= '0; pix_l <= '0;
      cx <= '0; cy <= '0; cz <= '0; vx <= '0; vy <= '0; vz <= '0; vc <= '0;
      clear_color <= '0; pcol <= '0; byte_idx <= '0; rd_pend <= 1'b0;
      m1_address <= '0; m1_writedata <= '0; m1_read <= 1'b0; m1_write <= 1'b0;
    end else begin
      if (s1_write) begin
        case (s1_address)
          8'd0: pix_base  <= s1_writedata;
          8'd1: vox_base  <= s1_writedata;
          8'd2: vox_count <= s1_writedata;
          8'd3: pal_base  <= s1_writedata;
          8'd4: pal_len   <= s1_writedata;
          8'd5:
            if (s1_writedata[0] && !busy) begin
              busy <= 1'b1; done <= 1'b0; state <= PAL0;
              ptr <= pix_base; pix_l <= pix_base; pix_left <= NPIX;
              vox_ptr <= vox_base; vox_left <= vox_count;
              pal_l <= pal_base; pal_len_l <= pal_len;
              cx <= cam[0][15:8]; cy <= cam[1][15:8]; cz <= cam[2][15:8];
            end
          8'd6: begin
            irq_en <= s1_writedata[0];
            if (s1_writedata[1]) done <= 1'b0;
          end
          default:
            if (s1_address[7:4] == 4'h1 && s1_address[3:0] != 4'hF)
              cam[s1_address[3:0]] <= s1_writedata[15:0];
        endcase
      end

      // Read data may arrive with acceptance or on a later cycle.
      if (m1_read && !m1_waitrequest) begin
        m1_read <= 1'b0;
        rd_pend <= ~m1_readdatavalid;
      end else if (rd_pend && m1_readdatavalid) begin
        rd_pend <= 1'b0;
      end
      if (wr_done) m1_write <= 1'b0;

      case (state)
        PAL0:
          if (pal_len_l == 32'd0) begin
            clear_color <= 8'd0;
            state <= CLEAR;
          end else if (bus_idle) begin
            m1_read <= 1'b1; m1_address <= pal_l;
          end else if (rd_done) begin
            clear_color <= m1_readdata;
            state <= CLEAR;
          end
        CLEAR:
          if (bus_idle) begin
            m1_write <= 1'b1; m1_address <= ptr; m1_writedata <= clear_color;
          end else if (wr_done) begin
            ptr <= ptr + 32'd1;
            pix_left <= pix_left - 32'd1;
            if (pix_left == 32'd1) begin
              byte_idx <= 2'd0;
              state <= (vox_left == 32'd0) ? DONE : VFETCH;
            end
          end
        VFETCH:
          if (bus_idle) begin
            m1_read <= 1'b1; m1_address <= vox_ptr + {30'd0, byte_idx};
          end else if (rd_done) begin
            case (byte_idx)
              2'd0: vx <= m1_readdata;
              2'd1: vy <= m1_readdata;
              2'd2: vz <= m1_readdata;
              default: vc <= m1_readdata;
            endcase
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= PROJ;
          end
        PROJ:
          if (!skip) state <= PFETCH;
        PFETCH:
          if (bus_idle) begin
            m1_read <= 1'b1; m1_address <= pal_l + {24'd0, vc};
          end else if (rd_done) begin
            pcol <= m1_readdata;
            state <= PLOT;
          end
        PLOT:
          if (bus_idle) begin
            m1_write <= 1'b1; m1_address <= pix_l + plot_off; m1_writedata <= pcol;
          end
        DONE: begin
          done <= 1'b1; busy <= 1'b0; state <= IDLE;
        end
        default: ;
      endcase

      if (next_vox) begin
        byte_idx <= 2'd0;
        if (vox_left == 32'd1) begin
          state <= DONE;
        end else begin
          vox_left <= vox_left - 32'd1;
          vox_ptr  <= vox_ptr + 32'd4;
          state    <= VFETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_voxel_gpu.sv
// Directed bench for voxel_gpu on a 4x4 frame with a wait-state byte memory model.
module tb_voxel_gpu;
  localparam int PIX = 'h200;

  logic        clock = 0, reset = 1;
  logic [7:0]  s1_address = 0;
  logic        s1_read = 0, s1_write = 0;
  logic [31:0] s1_readdata, s1_writedata = 0;
  logic        s1_waitrequest, irq;
  logic [31:0] m1_address;
  logic [7:0]  m1_writedata, m1_readdata;
  logic        m1_write, m1_read, m1_waitrequest, m1_readdatavalid;

  voxel_gpu #(.WIDTH(4), .HEIGHT(4)) dut (
    .clock(clock), .reset(reset),
    .s1_address(s1_address), .s1_read(s1_read), .s1_readdata(s1_readdata),
    .s1_writedata(s1_writedata), .s1_write(s1_write), .s1_waitrequest(s1_waitrequest),
    .irq(irq),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_write(m1_write),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_read(m1_read),
    .m1_readdatavalid(m1_readdatavalid)
  );

  always #5 clock = ~clock;

  logic [7:0]  mem [0:1023];
  int          ws = 0;
  bit          late = 0;
  int          wcnt = 0;
  logic        rv = 0;
  logic [7:0]  rq = 0;
  logic        tb_we = 0, clr = 0;
  logic [9:0]  tb_wa = 0;
  logic [7:0]  tb_wd = 0;
  int          wr_cnt = 0, act_cnt = 0, hold_err = 0, order_err = 0;
  logic        held = 0, h_rd = 0, h_wr = 0;
  logic [31:0] h_addr = 0;
  logic [7:0]  h_data = 0;
  logic        req;

  assign req              = m1_read | m1_write;
  assign m1_waitrequest   = req && (wcnt < ws);
  assign m1_readdatavalid = late ? rv : (m1_read && !m1_waitrequest);
  assign m1_readdata      = late ? rq : mem[m1_address[9:0]];

  always @(posedge clock) begin
    rv <= 1'b0;
    if (tb_we) mem[tb_wa] <= tb_wd;
    if (reset || !req || !m1_waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
    held <= !reset && req && m1_waitrequest;
    h_addr <= m1_address; h_rd <= m1_read; h_wr <= m1_write; h_data <= m1_writedata;
    if (clr) begin
      wr_cnt <= 0; act_cnt <= 0; hold_err <= 0; order_err <= 0;
    end else begin
      if (req) act_cnt <= act_cnt + 1;
      if ((m1_read && m1_write) ||
          (held && (m1_address != h_addr || m1_read != h_rd || m1_write != h_wr ||
                    (m1_write && m1_writedata != h_data))))
        hold_err <= hold_err + 1;
      if (m1_write && !m1_waitrequest) begin
        mem[m1_address[9:0]] <= m1_writedata;
        if (wr_cnt < 16 && m1_address != 32'(PIX + wr_cnt)) order_err <= order_err + 1;
        wr_cnt <= wr_cnt + 1;
      end
    end
    if (m1_read && !m1_waitrequest) begin
      rv <= 1'b1;
      rq <= mem[m1_address[9:0]];
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    s1_write = 1; s1_address = a; s1_writedata = d;
    @(posedge clock); #1;
    s1_write = 0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
    @(posedge clock); #1;
    s1_read = 1; s1_address = a;
    #2 d = s1_readdata;
    s1_read = 0;
  endtask

  task automatic mem_wr(input int a, input logic [7:0] d);
    @(posedge clock); #1;
    tb_we = 1; tb_wa = 10'(a); tb_wd = d;
    @(posedge clock); #1;
    tb_we = 0;
  endtask

  task automatic prep_frame();
    for (int i = 0; i < 16; i++) mem_wr(PIX + i, 8'hEE);
    @(posedge clock); #1 clr = 1;
    @(posedge clock); #1 clr = 0;
  endtask

  task automatic set_voxel(input int k, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] z, input logic [7:0] c);
    mem_wr('h80 + 4*k, x); mem_wr('h81 + 4*k, y);
    mem_wr('h82 + 4*k, z); mem_wr('h83 + 4*k, c);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] d;
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      reg_rd(8'd5, d);
      if (d == 32'd2) begin ok = 1; break; end
    end
    chk({tag, "_finished"}, 32'(ok), 32'd1);
  endtask

  task automatic check_pix(input string tag, input logic [7:0] bg, input int idx,
                           input logic [7:0] fg);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_pix%0d", tag, i), 32'(mem[PIX + i]), 32'((i == idx) ? fg : bg));
  endtask

  task automatic run_frame(input string tag, input int cnt, input int plen, input int nwr,
                           input logic [7:0] bg, input int idx, input logic [7:0] fg);
    prep_frame();
    reg_wr(8'd2, 32'(cnt));
    reg_wr(8'd4, 32'(plen));
    reg_wr(8'd5, 32'd1);
    wait_done(tag);
    check_pix(tag, bg, idx, fg);
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(nwr));
    chk({tag, "_order"}, 32'(order_err), 32'd0);
    chk({tag, "_hold"}, 32'(hold_err), 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_m1_read", 32'(m1_read), 32'd0);
    chk("rst_m1_write", 32'(m1_write), 32'd0);
    reg_rd(8'd5, rd);  chk("rst_status", rd, 32'd0);
    reg_rd(8'd16, rd); chk("rst_cam_x", rd, 32'd0);

    reg_wr(8'd16, 32'h0000_0500); reg_rd(8'd16, rd); chk("cam_x", rd, 32'h0000_0500);
    reg_wr(8'd17, 32'h0000_FF00); reg_rd(8'd17, rd); chk("cam_y_sext", rd, 32'hFFFF_FF00);
    reg_rd(8'd40, rd); chk("unmapped", rd, 32'd0);
    reg_wr(8'd30, 32'h0000_8001); reg_rd(8'd30, rd); chk("look3_z", rd, 32'hFFFF_8001);

    reg_wr(8'd17, 32'h0500); reg_wr(8'd18, 32'h0500);
    reg_wr(8'd0, PIX); reg_wr(8'd1, 32'h80); reg_wr(8'd3, 32'h40);
    mem_wr('h40, 8'h11); mem_wr('h41, 8'h22); mem_wr('h42, 8'h33);
    set_voxel(0, 8'd6, 8'd7, 8'd5, 8'd1);

    // sx=1, sy=2 -> byte 9
    ws = 0; late = 0; run_frame("single_ws0", 1, 2, 17, 8'h11, 9, 8'h22);
    ws = 3; late = 0; run_frame("single_ws3", 1, 2, 17, 8'h11, 9, 8'h22);
    ws = 1; late = 1; run_frame("single_late", 1, 2, 17, 8'h11, 9, 8'h22);

    ws = 0; late = 0;
    set_voxel(0, 8'd2, 8'd7, 8'd5, 8'd0);
    set_voxel(1, 8'd6, 8'd7, 8'd5, 8'd2);
    set_voxel(2, 8'd6, 8'd7, 8'd4, 8'd1);
    set_voxel(3, 8'd9, 8'd7, 8'd5, 8'd1);
    run_frame("clip", 4, 2, 16, 8'h11, -1, 8'h00);

    set_voxel(0, 8'd6, 8'd7, 8'd5, 8'd1);
    set_voxel(1, 8'd6, 8'd7, 8'd5, 8'd2);
    run_frame("overwrite", 2, 3, 18, 8'h11, 9, 8'h33);

    set_voxel(0, 8'd6, 8'd7, 8'd5, 8'd0);
    run_frame("pal_empty", 1, 0, 16, 8'h00, -1, 8'h00);

    reg_wr(8'd6, 32'd1);
    reg_rd(8'd6, rd); chk("irq_en_rd", rd, 32'd1);
    prep_frame();
    reg_wr(8'd2, 32'd0);
    reg_wr(8'd4, 32'd2);
    reg_wr(8'd5, 32'd1);
    chk("irq_low_busy", 32'(irq), 32'd0);
    reg_rd(8'd5, rd); chk("busy_flag", rd, 32'd1);
    reg_wr(8'd5, 32'd1);
    reg_wr(8'd0, 32'h300);
    wait_done("irq_frame");
    chk("irq_high", 32'(irq), 32'd1);
    repeat (60) @(posedge clock);
    #1 chk("single_completion", 32'(wr_cnt), 32'd16);
    chk("latched_base", 32'(order_err), 32'd0);
    check_pix("irq_frame", 8'h11, -1, 8'h00);
    reg_wr(8'd6, 32'd3);
    #1 chk("irq_cleared", 32'(irq), 32'd0);
    reg_rd(8'd5, rd); chk("done_cleared", rd, 32'd0);
    reg_rd(8'd6, rd); chk("irq_en_kept", rd, 32'd1);

    reg_wr(8'd0, PIX);
    ws = 3;
    prep_frame();
    reg_wr(8'd2, 32'd1);
    reg_wr(8'd5, 32'd1);
    repeat (20) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    chk("abort_read", 32'(m1_read), 32'd0);
    chk("abort_write", 32'(m1_write), 32'd0);
    chk("abort_irq", 32'(irq), 32'd0);
    @(posedge clock); #1 clr = 1;
    @(posedge clock); #1 clr = 0;
    repeat (40) @(posedge clock);
    #1 chk("abort_quiet", 32'(act_cnt), 32'd0);
    reg_rd(8'd0, rd); chk("abort_regs", rd, 32'd0);
    reg_rd(8'd5, rd); chk("abort_status", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/voxel_gpu.md
Name: voxel_gpu

Overview:
Memory-mapped voxel rasteriser with an Avalon-MM slave (s1) for configuration and status, and a byte-wide Avalon-MM master (m1) for memory access. On a start command it reads a palette and a voxel list from memory. It clears an 8-bit-per-pixel frame buffer to palette colour 0, then plots each voxel with an orthographic projection relative to the camera position. Completion raises a status flag and an optional irq.

Parameters:
WIDTH, 320, frame width in pixels.
HEIGHT, 240, frame height in pixels.

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
s1_address  in  8  register word index
s1_read  in  1  register read strobe
s1_readdata  out  32  register read data
s1_writedata  in  32  register write data
s1_write  in  1  register write strobe
s1_waitrequest  out  1  always 0
irq  out  1  interrupt, level
m1_address  out  32  byte address
m1_writedata  out  8  write byte
m1_write  out  1  write request
m1_waitrequest  in  1  stall; the request is held while high
m1_readdata  in  8  read byte
m1_read  out  1  read request
m1_readdatavalid  in  1  read data valid

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset clears all registers to 0, forces state IDLE, and drives m1_read=m1_write=irq=0. Reset mid-frame aborts the frame with no further bus activity.
- s1 register map (word index):
  - 0: pixel_buffer base.
  - 1: voxel_buffer base.
  - 2: voxel_count.
  - 3: palette_buffer base.
  - 4: palette_length.
  - 5: control/status. A write with bit0=1 starts a frame; it is ignored while busy. Read returns bit0=busy, bit1=done.
  - 6: irq control. Bit0=irq_en (read/write). Writing bit1=1 clears done.
  - 16..30: cam.pos.xyz and look0..look3.xyz as signed 8.8 fixed point in writedata[15:0]. Reads return the value sign-extended to 32 bits. The look vectors are stored only and do not affect rendering.
- Writes take effect on the rising edge where s1_write=1. s1_readdata is combinational from s1_address, valid in the same cycle. Unmapped reads return 0 and unmapped writes are ignored. A start also clears done.
- irq = done & irq_en.
- m1 handshake:
  - At most one transaction outstanding.
  - Address, data and strobe are held until a cycle with m1_waitrequest=0.
  - For reads, m1_readdata is captured in the first cycle at or after acceptance in which m1_readdatavalid=1; this may be the acceptance cycle itself.
  - m1_read and m1_write are never high together.
- State machine:
  - IDLE: on start, go to PAL0.
  - PAL0: if palette_length=0, clear_color=0x00. Otherwise read byte palette_buffer+0 into clear_color.
  - CLEAR: write clear_color to pixel_buffer+i for i=0..WIDTH*HEIGHT-1, ascending.
  - VFETCH: for voxel k, read 4 bytes at voxel_buffer+4k+0..3 into x, y, z, c (unsigned).
  - Projection: sx = x − cam.pos.x[15:8], sy = y − cam.pos.y[15:8], as 10-bit signed. The voxel is skipped if any of the following holds:
    - sx<0, sx≥WIDTH, sy<0, or sy≥HEIGHT;
    - z < cam.pos.z[15:8] (signed compare);
    - c ≥ palette_length.
  - PFETCH: read byte palette_buffer+c.
  - PLOT: write that byte to pixel_buffer+sy*WIDTH+sx. Later voxels overwrite earlier ones.
  - After the last voxel, or immediately if voxel_count=0, go to DONE.
  - DONE: set done, clear busy, return to IDLE.
- busy=1 from the start edge until DONE. Configuration registers may be written during a frame, but take effect only at the next start; they are latched at start.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Test Plan:
- Reset: assert reset for 1 cycle -> irq=0, m1_read=m1_write=0; reading reg 5 returns 0 and reading reg 16 returns 0.
- Register access: write reg 16=0x0500 -> read returns 0x00000500. Write reg 17=0xFF00 -> read returns 0xFFFFFF00. Read reg 40 -> 0.
- Single voxel, WIDTH=HEIGHT=4: palette {0x11,0x22} at palette_buffer, voxel (6,7,5,1), cam.pos=(5.0,5.0,5.0), start -> pixel byte 9 = 0x22, the other 15 bytes = 0x11, then done=1.
- Clipping and palette bounds, WIDTH=HEIGHT=4: voxel (2,…) with cam.x=5.0 (sx=−3), and a separate voxel with c=2 and palette_length=2 -> only clear writes occur (16 writes of palette[0]).
- Handshake: memory asserts waitrequest for 3 cycles per access with readdatavalid in the acceptance cycle -> address and strobe are held stable and the same frame result is produced. Repeat with waitrequest=0 and same-cycle valid.
- Interrupt: irq_en=1, frame with voxel_count=0 -> irq rises after the clear pass. Write reg 6=0x3 -> irq falls. Start while busy -> ignored, and the frame completes exactly once.
